hazard_sched: RTL and testbench
===============================

Name: hazard_sched

Overview:
- Pipeline scheduler for the three-stage RV32I core (F, D/X, W).
- Decides each cycle whether PC and the decode register advance, stall, or flush.
- Inserts bubbles into X and drives the operand-forwarding selects for the A/B muxes.
- Sits beside controlunit: it sequences the datapath that controlunit configures, and gates PC_sel's effect through pc_en.

Parameters:
BOOT_CYCLES, 2, cycles after reset release during which fetch is held while BIOS synchronous-read output settles (1..15)
FLUSH_CYCLES, 1, cycles d_flush is held starting at the redirect cycle (1..7)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
d_instr  in  32  instruction currently in decode
d_valid  in  1  d_instr is a real instruction
x_rd  in  5  destination register of the instruction in X
x_reg_we  in  1  X instruction writes rd
x_is_load  in  1  X instruction is a load
x_valid  in  1  X holds a real instruction
w_rd  in  5  destination register of the instruction in W
w_reg_we  in  1  W instruction writes rd
w_valid  in  1  W holds a real instruction
x_redirect  in  1  taken branch, JAL or JALR resolved in X
mem_busy  in  1  memory-mapped IO not ready; freeze the whole pipe
pc_en  out  1  PC register load enable
d_en  out  1  decode register load enable
d_flush  out  1  replace decode contents with NOP
x_bubble  out  1  load NOP into X instead of decode output
fwd_a  out  2  0 = regfile, 1 = X ALU result, 2 = W writeback data
fwd_b  out  2  same encoding as fwd_a, for rs2
sched_state  out  2  current FSM state, for debug

Behaviour:
- While rst = 0 at a clock edge:
  - state <= BOOT and boot_cnt <= 0.
  - Outputs: pc_en = 0, d_en = 0, d_flush = 1, x_bubble = 1, fwd_a = fwd_b = 0.
- Register use is decoded from d_instr:
  - rs1 is used by R-type, I-type ALU, LOAD, STORE, BRANCH, JALR, and CSR when funct3[2] = 0.
  - rs2 is used by R-type, STORE and BRANCH.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
  - If d_valid = 0, nothing is used.
- Hazard match: a source hazards with X or W only if valid, reg_we = 1, rd != 0 and rd equals the source register.
- Forwarding: fwd = 1 on an X match, else 2 on a W match, else 0. X takes priority over W.
- Load-use condition: X match with x_is_load = 1.
- FSM states: BOOT = 0, RUN = 1, LSTALL = 2, FLUSH = 3.
- BOOT:
  - Outputs as in reset.
  - boot_cnt increments each cycle.
  - On boot_cnt = BOOT_CYCLES-1, go to RUN.
- RUN, priority order:
  1. mem_busy = 1: pc_en = d_en = 0, x_bubble = 0, d_flush = 0, state held. Everything frozen; fwd still computed.
  2. x_redirect = 1: pc_en = 1, d_flush = 1, x_bubble = 1. If FLUSH_CYCLES > 1, go to FLUSH with flush_cnt = FLUSH_CYCLES-1.
  3. Load-use: pc_en = d_en = 0, x_bubble = 1, go to LSTALL.
  4. Otherwise: pc_en = d_en = 1, d_flush = 0, x_bubble = 0.
- LSTALL:
  - Exactly one cycle, behaving as RUN case 4 with fwd re-evaluated (the load is now in W, so fwd = 2).
  - mem_busy extends it.
  - x_redirect overrides it, as in RUN.
  - Return to RUN.
- FLUSH:
  - pc_en = 1, d_flush = 1, x_bubble = 1.
  - flush_cnt decrements; at 1, go to RUN.
  - A new x_redirect reloads flush_cnt = FLUSH_CYCLES-1.
  - mem_busy freezes the count.
- Simultaneous redirect and load-use: redirect wins, and no LSTALL is entered.
- rst low mid-stall or mid-flush aborts immediately to BOOT.
- Outputs are combinational from the registered state plus inputs. State and counters are updated on the rising edge of clk only.

Optional Feature:
- Macro: HAZARD_SCHED_PERF_EN.
- When defined, adds three output ports:
  - perf_stall_cnt, 32 bits: cycles in load-use stall.
  - perf_flush_cnt, 32 bits: cycles with d_flush = 1 outside BOOT.
  - perf_busy_cnt, 32 bits: cycles frozen by mem_busy.
- Counter behaviour: all cleared by rst, saturating at 32'hFFFF_FFFF.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header: opcode constants (existing Opcode.vh), FSM state encodings, and fwd select encodings (FWD_RF = 0, FWD_X = 1, FWD_W = 2), so the datapath muxes use the same values.
- One combinational sub-module, reg_use_decode: d_instr and d_valid in; rs1, rs2, use_rs1, use_rs2 out.

Test Plan:
- Boot: rst low 3 cycles, then high. pc_en = 0 for exactly 2 cycles after release, then 1; sched_state goes 0 -> 1.
- Forwarding:
  - X: addi x5 in X, add x6,x5,x7 in D -> fwd_a = 1, fwd_b = 0, no stall.
  - W: with x5 only in W -> fwd_a = 2.
  - x0: x_rd = 0 -> fwd_a = 0.
- Load-use: lw x5 in X, add x6,x5,x5 in D -> one cycle of pc_en = 0 and x_bubble = 1. Next cycle fwd_a = fwd_b = 2 and pc_en = 1.
- Redirect: x_redirect = 1 in the same cycle as a load-use hazard -> pc_en = 1, d_flush = 1, x_bubble = 1, no LSTALL. With FLUSH_CYCLES = 3, d_flush is held 3 cycles.
- mem_busy: held 4 cycles during LSTALL -> all enables 0 for those 4 cycles, then LSTALL completes. perf_busy_cnt = 4 with HAZARD_SCHED_PERF_EN.
- Mid-operation reset: rst low during FLUSH -> next edge sched_state = BOOT, outputs at reset values, perf counters = 0.

Source files
------------

// File: rtl/hazard_sched_pkg.sv
// Shared encodings for the pipeline scheduler: FSM states, forwarding selects and
// the RV32I opcodes the register-use decoder recognises.
package hazard_sched_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LSTALL = 2'd2,
        ST_FLUSH  = 2'd3
    } sched_state_e;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_X  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // X result is newer than W, so an X match always wins.
    function automatic logic [1:0] fwd_sel(input logic x_hit, input logic w_hit);
        if (x_hit)
            return FWD_X;
        else if (w_hit)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sched_reg_use_decode.sv
// Extracts rs1/rs2 from the decode-stage instruction and flags which of them the
// instruction actually reads.
module hazard_sched_reg_use_decode
    import hazard_sched_pkg::*;
(
    input  logic [31:0] d_instr,
    input  logic        d_valid,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        use_rs1,
    output logic        use_rs2
);

    logic unused_instr_bits;
    assign unused_instr_bits = ^{d_instr[31:25], d_instr[13:7]};

    always_comb begin
        rs1     = d_instr[19:15];
        rs2     = d_instr[24:20];
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (d_valid) begin
            case (d_instr[6:0])
                OP_RTYPE, OP_STORE, OP_BRANCH: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_IMM, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
                // Immediate CSR forms reuse the rs1 field as a zimm value.
                OP_SYSTEM: use_rs1 = ~d_instr[14];
                OP_LUI, OP_AUIPC, OP_JAL: begin
                    use_rs1 = 1'b0;
                    use_rs2 = 1'b0;
                end
                default: begin
                    use_rs1 = 1'b0;
                    use_rs2 = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline scheduler for the 3-stage RV32I core: stall/flush/bubble control and
// operand forwarding selects. HAZARD_SCHED_PERF_EN adds saturating perf counters.
//
// state  | meaning
// BOOT   | fetch held while BIOS read data settles
// RUN    | normal issue; detects load-use and redirects
// LSTALL | load now in W, decode re-issued with W forwarding
// FLUSH  | extra post-redirect cycles with decode flushed
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_instr,
    input  logic        d_valid,
    input  logic [4:0]  x_rd,
    input  logic        x_reg_we,
    input  logic        x_is_load,
    input  logic        x_valid,
    input  logic [4:0]  w_rd,
    input  logic        w_reg_we,
    input  logic        w_valid,
    input  logic        x_redirect,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        d_en,
    output logic        d_flush,
    output logic        x_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  sched_state
`ifdef HAZARD_SCHED_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_busy_cnt
`endif
);

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    sched_state_e state;
    logic [3:0]   boot_cnt;
    logic [2:0]   flush_cnt;

    logic [4:0] rs1, rs2;
    logic       use_rs1, use_rs2;
    logic       x_hit_a, x_hit_b, w_hit_a, w_hit_b;
    logic       load_use;

    hazard_sched_reg_use_decode u_reg_use_decode (
        .d_instr (d_instr),
        .d_valid (d_valid),
        .rs1     (rs1),
        .rs2     (rs2),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    assign x_hit_a  = use_rs1 && x_valid && x_reg_we && (x_rd != 5'd0) && (x_rd == rs1);
    assign x_hit_b  = use_rs2 && x_valid && x_reg_we && (x_rd != 5'd0) && (x_rd == rs2);
    assign w_hit_a  = use_rs1 && w_valid && w_reg_we && (w_rd != 5'd0) && (w_rd == rs1);
    assign w_hit_b  = use_rs2 && w_valid && w_reg_we && (w_rd != 5'd0) && (w_rd == rs2);
    assign load_use = x_is_load && (x_hit_a || x_hit_b);

    assign sched_state = state;

    always_comb begin
        pc_en    = 1'b0;
        d_en     = 1'b0;
        d_flush  = 1'b1;
        x_bubble = 1'b1;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        if (state != ST_BOOT) begin
            fwd_a = fwd_sel(x_hit_a, w_hit_a);
            fwd_b = fwd_sel(x_hit_b, w_hit_b);
            if (mem_busy) begin
                d_flush  = 1'b0;
                x_bubble = 1'b0;
            end else if (x_redirect || state == ST_FLUSH) begin
                pc_en = 1'b1;
                d_en  = 1'b1;
            end else if (state == ST_RUN && load_use) begin
                d_flush = 1'b0;
            end else begin
                pc_en    = 1'b1;
                d_en     = 1'b1;
                d_flush  = 1'b0;
                x_bubble = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_BOOT;
            boot_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST)
                        state <= ST_RUN;
                end
                ST_RUN, ST_LSTALL: begin
                    if (!mem_busy) begin
                        if (x_redirect) begin
                            state <= ST_RUN;
                            if (FLUSH_CYCLES > 1) begin
                                state     <= ST_FLUSH;
                                flush_cnt <= FLUSH_LOAD;
                            end
                        end else if (state == ST_RUN && load_use) begin
                            state <= ST_LSTALL;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!mem_busy) begin
                        if (x_redirect)
                            flush_cnt <= FLUSH_LOAD;
                        else if (flush_cnt <= 3'd1)
                            state <= ST_RUN;
                        else
                            flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

`ifdef HAZARD_SCHED_PERF_EN
    logic stall_lu;
    assign stall_lu = (state == ST_RUN) && !mem_busy && !x_redirect && load_use;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_busy_cnt  <= '0;
        end else begin
            if (stall_lu && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (state != ST_BOOT && d_flush && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (state != ST_BOOT && mem_busy && perf_busy_cnt != 32'hFFFF_FFFF)
                perf_busy_cnt <= perf_busy_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched (BOOT_CYCLES=2, FLUSH_CYCLES=3); perf counters
// are checked when HAZARD_SCHED_PERF_EN is defined.
module tb_hazard_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_instr;
    logic        d_valid;
    logic [4:0]  x_rd;
    logic        x_reg_we, x_is_load, x_valid;
    logic [4:0]  w_rd;
    logic        w_reg_we, w_valid;
    logic        x_redirect, mem_busy;
    logic        pc_en, d_en, d_flush, x_bubble;
    logic [1:0]  fwd_a, fwd_b, sched_state;
`ifdef HAZARD_SCHED_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_busy_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_sched #(.BOOT_CYCLES(2), .FLUSH_CYCLES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .d_instr     (d_instr),
        .d_valid     (d_valid),
        .x_rd        (x_rd),
        .x_reg_we    (x_reg_we),
        .x_is_load   (x_is_load),
        .x_valid     (x_valid),
        .w_rd        (w_rd),
        .w_reg_we    (w_reg_we),
        .w_valid     (w_valid),
        .x_redirect  (x_redirect),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .d_en        (d_en),
        .d_flush     (d_flush),
        .x_bubble    (x_bubble),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .sched_state (sched_state)
`ifdef HAZARD_SCHED_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_busy_cnt  (perf_busy_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3);
        return {7'b0, rs2, rs1, f3, rd, op};
    endfunction

    // Advance one edge and land just after it; checks follow a short settle delay.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        d_instr = 32'h0000_0013; d_valid = 1'b0;
        x_rd = 5'd0; x_reg_we = 1'b0; x_is_load = 1'b0; x_valid = 1'b0;
        w_rd = 5'd0; w_reg_we = 1'b0; w_valid = 1'b0;
        x_redirect = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_x(input logic [4:0] rd, input logic is_load);
        x_rd = rd; x_reg_we = 1'b1; x_valid = 1'b1; x_is_load = is_load;
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] st, input logic pc,
                              input logic de, input logic fl, input logic bub);
        check({tag, "_state"}, 32'(sched_state), 32'(st));
        check({tag, "_pc_en"}, 32'(pc_en), 32'(pc));
        check({tag, "_d_en"}, 32'(d_en), 32'(de));
        check({tag, "_d_flush"}, 32'(d_flush), 32'(fl));
        check({tag, "_x_bubble"}, 32'(x_bubble), 32'(bub));
    endtask

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] S_OP   = 7'b0100011;
    localparam logic [6:0] LUI_OP = 7'b0110111;
    localparam logic [6:0] SYS_OP = 7'b1110011;

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Reset and boot hold
        repeat (3) @(posedge clk);
        #1;
        check_ctrl("reset", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("reset_fwd_a", 32'(fwd_a), 32'd0);
        rst = 1'b1;
        #2 check_ctrl("boot1", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        #2 check_ctrl("boot2", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        #2 check_ctrl("run0", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Forwarding patterns
        tick();
        set_x(5'd5, 1'b0);
        d_valid = 1'b1; d_instr = enc(R_OP, 5'd6, 5'd5, 5'd7, 3'b000);
        #2 check("fwdx_a", 32'(fwd_a), 32'd1);
        check("fwdx_b", 32'(fwd_b), 32'd0);
        check_ctrl("fwdx", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        tick();
        w_rd = 5'd5; w_reg_we = 1'b1; w_valid = 1'b1;
        #2 check("fwd_prio_a", 32'(fwd_a), 32'd1);
        tick();
        x_valid = 1'b0;
        #2 check("fwdw_a", 32'(fwd_a), 32'd2);
        check("fwdw_b", 32'(fwd_b), 32'd0);

        tick();
        idle_inputs();
        set_x(5'd0, 1'b0);
        w_rd = 5'd0; w_reg_we = 1'b1; w_valid = 1'b1;
        d_valid = 1'b1; d_instr = enc(R_OP, 5'd6, 5'd0, 5'd7, 3'b000);
        #2 check("fwd_x0_a", 32'(fwd_a), 32'd0);

        tick();
        idle_inputs();
        set_x(5'd7, 1'b0);
        d_valid = 1'b1; d_instr = enc(S_OP, 5'd0, 5'd5, 5'd7, 3'b010);
        #2 check("store_a", 32'(fwd_a), 32'd0);
        check("store_b", 32'(fwd_b), 32'd1);

        tick();
        set_x(5'd5, 1'b1);
        d_instr = enc(LUI_OP, 5'd6, 5'd5, 5'd5, 3'b000);
        #2 check("lui_a", 32'(fwd_a), 32'd0);
        check("lui_pc_en", 32'(pc_en), 32'd1);

        tick();
        set_x(5'd5, 1'b0);
        d_instr = enc(SYS_OP, 5'd6, 5'd5, 5'd0, 3'b010);
        #2 check("csrrs_a", 32'(fwd_a), 32'd1);
        tick();
        d_instr = enc(SYS_OP, 5'd6, 5'd5, 5'd0, 3'b110);
        #2 check("csrrsi_a", 32'(fwd_a), 32'd0);
        tick();
        d_instr = enc(R_OP, 5'd6, 5'd5, 5'd5, 3'b000);
        d_valid = 1'b0;
        #2 check("dinvalid_a", 32'(fwd_a), 32'd0);

        // Load-use stall
        tick();
        idle_inputs();
        set_x(5'd5, 1'b1);
        d_valid = 1'b1; d_instr = enc(R_OP, 5'd6, 5'd5, 5'd5, 3'b000);
        #2 check_ctrl("lu_stall", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("lu_stall_fwd_a", 32'(fwd_a), 32'd1);
        tick();
        x_valid = 1'b0; x_is_load = 1'b0;
        w_rd = 5'd5; w_reg_we = 1'b1; w_valid = 1'b1;
        #2 check_ctrl("lu_lstall", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("lu_lstall_fwd_a", 32'(fwd_a), 32'd2);
        check("lu_lstall_fwd_b", 32'(fwd_b), 32'd2);
        tick();
        idle_inputs();
        #2 check("lu_back_state", 32'(sched_state), 32'd1);

        // Redirect beats load-use, then FLUSH_CYCLES=3 of d_flush
        tick();
        set_x(5'd5, 1'b1);
        d_valid = 1'b1; d_instr = enc(R_OP, 5'd6, 5'd5, 5'd5, 3'b000);
        x_redirect = 1'b1;
        #2 check_ctrl("redir0", 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle_inputs();
        #2 check_ctrl("redir1", 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        #2 check_ctrl("redir2", 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        #2 check_ctrl("redir_done", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        // mem_busy extends LSTALL
        tick();
        set_x(5'd5, 1'b1);
        d_valid = 1'b1; d_instr = enc(R_OP, 5'd6, 5'd5, 5'd5, 3'b000);
        tick();
        x_valid = 1'b0; x_is_load = 1'b0;
        w_rd = 5'd5; w_reg_we = 1'b1; w_valid = 1'b1;
        mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 check_ctrl($sformatf("busy%0d", i), 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        mem_busy = 1'b0;
        #2 check_ctrl("busy_release", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("busy_release_fwd_a", 32'(fwd_a), 32'd2);
        tick();
        idle_inputs();
        #2 check("busy_back_state", 32'(sched_state), 32'd1);
`ifdef HAZARD_SCHED_PERF_EN
        check("perf_busy", perf_busy_cnt, 32'd4);
        check("perf_stall", perf_stall_cnt, 32'd2);
        check("perf_flush", perf_flush_cnt, 32'd3);
`endif

        // mem_busy freezes RUN while forwarding still resolves
        tick();
        set_x(5'd5, 1'b0);
        d_valid = 1'b1; d_instr = enc(R_OP, 5'd6, 5'd5, 5'd7, 3'b000);
        mem_busy = 1'b1;
        #2 check_ctrl("run_busy", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("run_busy_fwd_a", 32'(fwd_a), 32'd1);

        // Reset in the middle of FLUSH
        tick();
        idle_inputs();
        x_redirect = 1'b1;
        tick();
        x_redirect = 1'b0;
        #2 check("mid_flush_state", 32'(sched_state), 32'd3);
        tick();
        rst = 1'b0;
        tick();
        #2 check_ctrl("mid_rst", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mid_rst_fwd_b", 32'(fwd_b), 32'd0);
`ifdef HAZARD_SCHED_PERF_EN
        check("mid_rst_perf_busy", perf_busy_cnt, 32'd0);
        check("mid_rst_perf_flush", perf_flush_cnt, 32'd0);
        check("mid_rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        rst = 1'b1;
        tick();
        #2 check("reboot_state1", 32'(sched_state), 32'd0);
        tick();
        #2 check("reboot_state2", 32'(sched_state), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
